// File: rtl/prog_mem_loader.sv
// Program memory loader: assembles a byte stream MSB-first into instruction words,
// stores them until a halt word or a full memory, then serves 1-cycle-latency fetches.
module prog_mem_loader #(
    parameter int NBITS_O  = 11,
    parameter int NBITS_D  = 16,
    parameter int CELDAS   = 64,
    parameter int NBITS_OP = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Start,
    input  logic [7:0]         i_Byte,
    input  logic               i_ByteValid,
    input  logic               i_RdEn,
    input  logic [NBITS_O-1:0] i_Addr,
    output logic [NBITS_D-1:0] o_Data,
    output logic               o_DataValid,
    output logic               o_Loading,
    output logic               o_Ready,
    output logic [NBITS_O:0]   o_WordCount,
    output logic               o_Overflow
);

    localparam int NB  = NBITS_D / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW  = (CELDAS > 1) ? $clog2(CELDAS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} state_t;

    state_t             state_q;
    logic [BCW-1:0]     byte_cnt_q;
    logic [NBITS_D-1:0] word_q;
    logic [NBITS_D-1:0] word_d;
    logic [NBITS_O:0]   word_count_q;
    logic               overflow_q;
    logic               loading_q;
    logic               ready_q;
    logic               data_valid_q;
    logic [NBITS_D-1:0] data_q;

    logic [NBITS_D-1:0] mem [CELDAS];

    logic last_byte;
    logic wr_en;
    logic is_halt;
    logic is_full;
    logic rd_hit;

    // Each byte lane takes the incoming byte when the byte counter points at it.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign word_d[NBITS_D-1-8*gi -: 8] =
                (byte_cnt_q == BCW'(gi)) ? i_Byte : word_q[NBITS_D-1-8*gi -: 8];
        end
    endgenerate

    assign last_byte = (byte_cnt_q == BCW'(NB - 1));
    assign wr_en     = (state_q == ST_LOAD) && !i_Start && i_ByteValid && last_byte;
    assign is_halt   = (word_d[NBITS_D-1 -: NBITS_OP] == '0);
    assign is_full   = (word_count_q == (NBITS_O+1)'(CELDAS - 1));
    assign rd_hit    = ({1'b0, i_Addr} < word_count_q);

    always_ff @(posedge i_clk) begin
        if (!i_reset && wr_en) begin
            mem[word_count_q[AW-1:0]] <= word_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            loading_q    <= 1'b0;
            ready_q      <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            data_valid_q <= 1'b0;
            if (i_RdEn) begin
                if (state_q == ST_READY) begin
                    data_valid_q <= 1'b1;
                    data_q       <= rd_hit ? mem[i_Addr[AW-1:0]] : '0;
                end else begin
                    data_q <= '0;
                end
            end

            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (i_Start) begin
                        state_q      <= ST_LOAD;
                        loading_q    <= 1'b1;
                        ready_q      <= 1'b0;
                        byte_cnt_q   <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (i_Start) begin
                        byte_cnt_q   <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                    end else if (i_ByteValid) begin
                        word_q <= word_d;
                        if (last_byte) begin
                            byte_cnt_q   <= '0;
                            word_count_q <= word_count_q + (NBITS_O+1)'(1);
                            if (is_halt || is_full) begin
                                state_q    <= ST_READY;
                                loading_q  <= 1'b0;
                                ready_q    <= 1'b1;
                                overflow_q <= !is_halt;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    loading_q <= 1'b0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_Data      = data_q;
    assign o_DataValid = data_valid_q;
    assign o_Loading   = loading_q;
    assign o_Ready     = ready_q;
    assign o_WordCount = word_count_q;
    assign o_Overflow  = overflow_q;

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter NBITS_O, default 11, address width.
REQ-002 SHALL have parameter NBITS_D, default 16, instruction width; an integer multiple of 8.
REQ-003 SHALL have parameter CELDAS, default 64, memory depth in words; CELDAS <= 2**NBITS_O.
REQ-004 SHALL have parameter NBITS_OP, default 5, opcode field width, located at bits [NBITS_D-1 : NBITS_D-NBITS_OP].
REQ-005 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  rising-edge clock.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_Start  in  1  one-cycle pulse that begins or restarts a program load.
REQ-008 i_Byte  in  8  load byte.
REQ-009 i_ByteValid  in  1  i_Byte is valid this cycle.
REQ-010 i_RdEn  in  1  instruction fetch request.
REQ-011 i_Addr  in  NBITS_O  fetch address.
REQ-012 o_Data  out  NBITS_D  fetched instruction.
REQ-013 o_DataValid  out  1  o_Data is valid this cycle.
REQ-014 o_Loading  out  1  FSM is in LOAD.
REQ-015 o_Ready  out  1  FSM is in READY; program is executable.
REQ-016 o_WordCount  out  NBITS_O+1  number of words written in the current or last load.
REQ-017 o_Overflow  out  1  last load filled the memory without a halt word.

Function
REQ-018 FSM SHALL have three states: IDLE, LOAD and READY.
REQ-019 IDLE/READY + i_Start -> LOAD next cycle; clears o_WordCount, the byte counter and o_Overflow.
REQ-020 i_Start in LOAD SHALL restart the load: counters cleared, partially assembled word discarded, state stays LOAD.
REQ-021 In LOAD, each i_ByteValid SHALL be assembled MSB-first: byte k of a word lands in bits [NBITS_D-1-8k : NBITS_D-8-8k].
REQ-022 On the cycle carrying byte NBITS_D/8 of a word, the assembled word SHALL be written at address o_WordCount at that clock edge; o_WordCount increments by 1.
REQ-023 If the written word's opcode field == 0 (halt), the FSM SHALL go to READY next cycle; the halt word is stored and counted.
REQ-024 If the write fills address CELDAS-1 with a non-halt word, the FSM SHALL go to READY with o_Overflow=1.
REQ-025 i_Start and i_ByteValid in the same cycle: i_Start wins and the byte is dropped.
REQ-026 i_ByteValid outside LOAD SHALL be ignored; memory is unchanged.
REQ-027 Reads SHALL have 1-cycle latency: i_RdEn in READY at edge N -> o_Data = mem[i_Addr] and o_DataValid=1 after edge N+1.
REQ-028 A read with i_Addr >= o_WordCount SHALL return all-zero (halt) with o_DataValid=1.
REQ-029 i_RdEn outside READY SHALL return o_Data=0 and o_DataValid=0.
REQ-030 Without i_RdEn, o_DataValid=0 and o_Data holds its last value.
REQ-031 Memory contents SHALL persist across a READY->LOAD transition until overwritten; reads remain gated until READY.

Reset
REQ-032 i_reset SHALL take priority over all inputs and, at the next edge, set: state IDLE, o_Data=0, o_DataValid=0, o_Loading=0, o_Ready=0, o_WordCount=0, o_Overflow=0, byte counter=0.
REQ-033 Reset SHALL NOT be required to clear memory contents; a reset mid-load SHALL abandon the load.

Verification
REQ-034 Reset, then Start, then bytes 10 01 28 02 00 00 (NBITS_D=16) -> words 0x1001, 0x2802, 0x0000; o_Ready=1 and o_WordCount=3 the cycle after the last byte; o_Overflow=0.
REQ-035 In READY, RdEn at Addr 0,1,2,5 on consecutive cycles -> one cycle later o_Data = 0x1001, 0x2802, 0x0000, 0x0000 with o_DataValid=1 each cycle.
REQ-036 CELDAS=4, load 4 non-halt words (0x0801..0x0804) -> READY, o_Overflow=1, o_WordCount=4; the 5th byte pair is ignored.
REQ-037 Start mid-word (after byte 0x10), then bytes 18 08 00 00 -> mem[0]=0x1808, o_WordCount=2; no 0x10xx word written.
REQ-038 Reset asserted during LOAD with ByteValid=1 -> next cycle IDLE with all outputs 0; RdEn gives o_DataValid=0.
REQ-039 i_Start and i_ByteValid together in LOAD -> counters cleared, byte dropped; RdEn during LOAD gives o_DataValid=0.
